// File: rtl/systolic_feeder_4x4.sv
// systolic_feeder_4x4
// Operand feeder for a 4x4 signed int8 systolic array. Accepts K operand
// beats (a column of A and a row of B per beat), skews lane n by n cycles
// onto the west/north array edges, issues the one-cycle array clear and
// pulses done in the first cycle in which every PE accumulator is final.
module systolic_feeder_4x4 #(
  parameter int K = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_col,
  input  logic [31:0] b_row,
  output logic [31:0] a_edge,
  output logic [31:0] b_edge,
  output logic        clear,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_FEED  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [7:0] LAST_BEAT = 8'(K - 1);

  // Drain edge on which PE(3,3) registers its last operand pair
  localparam logic [2:0] DRAIN_DONE = 3'd6;
  // Final drain count; the done cycle is the last cycle spent in DRAIN
  localparam logic [2:0] DRAIN_LAST = 3'd7;

  logic [1:0]  state_r;
  logic [1:0]  state_nx_s;
  logic [7:0]  beat_cnt_r;
  logic [2:0]  drain_cnt_r;
  logic        accept_s;
  logic        last_beat_s;
  logic [31:0] a_beat_s;
  logic [31:0] b_beat_s;

  // in_ready is only ever high in FEED, so this is the full acceptance term
  assign accept_s    = in_valid & in_ready;
  assign last_beat_s = accept_s & (beat_cnt_r == LAST_BEAT);

  // A cycle without an accepted beat injects a zero bubble into every lane
  assign a_beat_s = accept_s ? a_col : 32'd0;
  assign b_beat_s = accept_s ? b_row : 32'd0;

  // Next-state decode for the IDLE/CLEAR/FEED/DRAIN sequence
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_CLEAR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_nx_s = ST_FEED;
      end
      ST_FEED: begin
        if (last_beat_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register plus beat and drain counters (both zeroed in CLEAR)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= 8'd0;
      drain_cnt_r <= 3'd0;
    end else begin
      state_r <= state_nx_s;
      if (state_r == ST_CLEAR) begin
        beat_cnt_r <= 8'd0;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end
      if (state_r == ST_CLEAR) begin
        drain_cnt_r <= 3'd0;
      end else if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_cnt_r + 3'd1;
      end
    end
  end

  // Registered control outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear    <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      clear    <= (state_nx_s == ST_CLEAR);
      in_ready <= (state_nx_s == ST_FEED);
      busy     <= (state_nx_s != ST_IDLE);
      done     <= (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_DONE);
    end
  end

  // Per-lane skew: lane n is an (n+1)-deep shift chain whose head is the
  // edge output register, so lane n reaches the array n cycles after lane 0.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] a_sh_r [0:i];
    logic [7:0] b_sh_r [0:i];

    // Load the new beat (or a zero bubble) and shift toward the array edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          a_sh_r[s] <= 8'd0;
          b_sh_r[s] <= 8'd0;
        end
      end else begin
        a_sh_r[0] <= a_beat_s[8*i +: 8];
        b_sh_r[0] <= b_beat_s[8*i +: 8];
        for (int s = 1; s <= i; s++) begin
          a_sh_r[s] <= a_sh_r[s-1];
          b_sh_r[s] <= b_sh_r[s-1];
        end
      end
    end

    assign a_edge[8*i +: 8] = a_sh_r[i];
    assign b_edge[8*i +: 8] = b_sh_r[i];
  end

endmodule
